// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM state encoding,
// default timing constants and the frame parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    // Default host timing, in microseconds
    localparam int DEFAULT_INHIBIT_US = 120;
    localparam int DEFAULT_TIMEOUT_US = 20_000;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for one PS/2 line plus falling-edge detect.
// The edge pulse appears one cycle after the synchronised level drops.
module ps2_sync (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic line_sync,
    output logic line_fall
);

    logic meta;
    logic sync;
    logic sync_d;

    // Resynchronise the line; idle level of a PS/2 line is high
    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b1;
            sync   <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            meta   <= line_in;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign line_sync = sync;
    assign line_fall = sync_d & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter with open-drain clock/data drivers.
// Optional macro PS2_TX_ACK_CHECK_EN: when defined, a missing device ACK on
// the eleventh clock reports tx_err instead of tx_done.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int INHIBIT_US = DEFAULT_INHIBIT_US,
    parameter int TIMEOUT_US = DEFAULT_TIMEOUT_US
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    inout  wire        ps2_clk,
    inout  wire        ps2_data
);

    localparam int INHIBIT_CYCLES = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int MAX_CYCLES     = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W          = $clog2(MAX_CYCLES + 1);

    localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    ps2_state_t       state;
    logic [TMR_W-1:0] tmr;       // inhibit hold timer, then reused as device timeout
    logic [3:0]       bit_cnt;   // device falling edges seen in this frame
    logic [8:0]       shreg;     // {parity, data}, shifted out LSB first
    logic             clk_oe;    // 1 = pull ps2_clk low
    logic             data_oe;   // 1 = pull ps2_data low
`ifdef PS2_TX_ACK_CHECK_EN
    logic             ack_ok;
`endif

    logic clk_sync;
    logic clk_fall;
    logic data_sync;
    logic data_fall;
    logic tmo_hit;

    ps2_sync u_sync_clk (
        .clk       (clk),
        .reset     (reset),
        .line_in   (ps2_clk),
        .line_sync (clk_sync),
        .line_fall (clk_fall)
    );

    ps2_sync u_sync_data (
        .clk       (clk),
        .reset     (reset),
        .line_in   (ps2_data),
        .line_sync (data_sync),
        .line_fall (data_fall)
    );

    // The transmitter never needs the data-line edge
    logic unused_data_fall;
    assign unused_data_fall = data_fall;

    // Open-drain drivers: only ever pull low or float
    assign ps2_clk  = clk_oe  ? 1'b0 : 1'bz;
    assign ps2_data = data_oe ? 1'b0 : 1'bz;

    // Device timeout only applies while the device owns the clock
    assign tmo_hit = ((state == SHIFT) || (state == ACK)) && (tmr == TMO_LAST);

    // Transmit sequencer: inhibit, request-to-send, shift 10 bits, read ACK, wait idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tmr      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            clk_oe   <= 1'b0;
            data_oe  <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_ok   <= 1'b0;
`endif
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            if (tmo_hit) begin
                clk_oe   <= 1'b0;
                data_oe  <= 1'b0;
                tx_err   <= 1'b1;
                tx_ready <= 1'b1;
                tx_busy  <= 1'b0;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (tx_valid) begin
                            shreg    <= {odd_parity(tx_data), tx_data};
                            tmr      <= '0;
                            bit_cnt  <= '0;
                            clk_oe   <= 1'b1;
                            tx_ready <= 1'b0;
                            tx_busy  <= 1'b1;
                            state    <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (tmr == INH_LAST) begin
                            tmr     <= '0;
                            data_oe <= 1'b1;   // start bit
                            state   <= REQ;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    REQ: begin
                        clk_oe <= 1'b0;
                        tmr    <= '0;
                        state  <= SHIFT;
                    end
                    SHIFT: begin
                        tmr <= tmr + 1'b1;
                        if (clk_fall) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd9) begin
                                data_oe <= 1'b0;   // stop bit: release the line
                                state   <= ACK;
                            end else begin
                                data_oe <= ~shreg[0];
                                shreg   <= {1'b1, shreg[8:1]};
                            end
                        end
                    end
                    ACK: begin
                        tmr <= tmr + 1'b1;
                        if (clk_fall) begin
                            bit_cnt <= bit_cnt + 4'd1;
`ifdef PS2_TX_ACK_CHECK_EN
                            ack_ok  <= ~data_sync;
`endif
                            state   <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_sync && data_sync) begin
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                            state    <= IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
                            if (ack_ok) tx_done <= 1'b1;
                            else        tx_err  <= 1'b1;
`else
                            tx_done <= 1'b1;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a PS/2 device model.
// Honours PS2_TX_ACK_CHECK_EN when choosing the expected NACK outcome.
module tb_ps2_host_tx;

    localparam int CLK_HZ = 2_000_000;
    localparam int INH_US = 10;
    localparam int TMO_US = 300;
    localparam int INH    = CLK_HZ / 1_000_000 * INH_US;   // 20 cycles
    localparam int TMO    = CLK_HZ / 1_000_000 * TMO_US;   // 600 cycles
`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    wire        ps2_clk;
    wire        ps2_data;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int acc_cnt = 0;

    always #5 clk = ~clk;

    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_data);

    ps2_host_tx #(
        .CLK_HZ     (CLK_HZ),
        .INHIBIT_US (INH_US),
        .TIMEOUT_US (TMO_US)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_err   (tx_err),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    // Pulse and handshake monitors
    always @(negedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err)  err_cnt  <= err_cnt + 1;
        if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    end

    always @(posedge clk) begin
        if (!reset && tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a byte for one accept cycle, then scramble tx_data
    task automatic start_tx(input logic [7:0] b);
        chk("ready_before_send", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~b;
    endtask

    // Measure clock inhibit and check the start bit / clock release
    task automatic inhibit_phase();
        int n = 0;
        chk("busy_after_accept", tx_busy, 1);
        chk("ready_after_accept", tx_ready, 0);
        while (ps2_clk === 1'b0 && ps2_data === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        chk("inhibit_cycles", n, INH);
        chk("req_clk_still_low", ps2_clk, 0);
        chk("req_data_low", ps2_data, 0);
        @(negedge clk);
        chk("clk_released", ps2_clk, 1);
        chk("start_bit_low", ps2_data, 0);
    endtask

    // Device model: clocks 11 edges, samples bits 1-10, answers ACK on edge 11
    task automatic dev_clock(input logic [7:0] b, input bit ack, input int lo, input int hi,
                             input int abort_edge);
        logic [10:0] frame;
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        frame = {1'b1, (ones % 2 == 0), b, 1'b0};
        for (int k = 1; k <= 10; k++) begin
            repeat (hi) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (lo) @(negedge clk);
            if (k == abort_edge) return;
            chk($sformatf("frame_bit%0d_of_%02h", k, b), ps2_data, frame[k]);
            dev_clk_low = 1'b0;
        end
        repeat (hi) @(negedge clk);
        dev_data_low = ack;
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (lo) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (hi) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_result(input int d0, input int e0, input bit exp_done);
        int g = 0;
        while (done_cnt == d0 && err_cnt == e0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt - d0, exp_done ? 1 : 0);
        chk("err_pulses", err_cnt - e0, exp_done ? 0 : 1);
        chk("ready_idle", tx_ready, 1);
        chk("busy_idle", tx_busy, 0);
        chk("clk_idle_high", ps2_clk, 1);
        chk("data_idle_high", ps2_data, 1);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit ack, input int lo, input int hi);
        int d0, e0;
        start_tx(b);
        inhibit_phase();
        d0 = done_cnt;
        e0 = err_cnt;
        dev_clock(b, ack, lo, hi, 0);
        wait_result(d0, e0, ack || !ACK_CHECK);
    endtask

    initial begin
        int d0, e0, a0, j;
        logic [7:0] rb;
        bit ra;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_err", tx_err, 0);
        chk("rst_clk_hiz", ps2_clk, 1);
        chk("rst_data_hiz", ps2_data, 1);
        reset = 1'b0;
        @(negedge clk);

        // Directed frames: parity 1, parity 0, all-zero data, NACK
        send_frame(8'hED, 1'b1, 8, 8);
        send_frame(8'hF4, 1'b1, 8, 8);
        send_frame(8'h00, 1'b1, 6, 7);
        send_frame(8'hFF, 1'b0, 8, 8);

        // Device never clocks: timeout
        start_tx(8'h5A);
        inhibit_phase();
        j = 0;
        while (!tx_err && j < TMO + 100) begin
            @(negedge clk);
            j++;
        end
        chk("tmo_cycles", j, TMO);
        chk("tmo_err", tx_err, 1);
        chk("tmo_clk_hiz", ps2_clk, 1);
        chk("tmo_data_hiz", ps2_data, 1);
        chk("tmo_ready", tx_ready, 1);
        chk("tmo_busy", tx_busy, 0);
        repeat (5) @(negedge clk);

        // Reset at edge 5 of 0xED, with tx_valid raised in the same cycle
        start_tx(8'hED);
        inhibit_phase();
        d0 = done_cnt;
        e0 = err_cnt;
        dev_clock(8'hED, 1'b1, 8, 8, 5);
        chk("abort_bit4_driven", ps2_data, 0);
        reset       = 1'b1;
        tx_valid    = 1'b1;
        dev_clk_low = 1'b0;
        @(negedge clk);
        chk("abort_clk_hiz", ps2_clk, 1);
        chk("abort_data_hiz", ps2_data, 1);
        chk("abort_ready", tx_ready, 1);
        chk("abort_busy", tx_busy, 0);
        reset    = 1'b0;
        tx_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_no_err", err_cnt - e0, 0);
        send_frame(8'hFF, 1'b1, 8, 8);

        // tx_valid held with 0xAA: one accept per transfer
        a0 = acc_cnt;
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk);
        inhibit_phase();
        dev_clock(8'hAA, 1'b1, 7, 7, 0);
        j = 0;
        while (!tx_done && j < 100) begin
            @(negedge clk);
            j++;
        end
        chk("hold_done", tx_done, 1);
        chk("hold_single_accept", acc_cnt - a0, 1);
        chk("hold_ready_at_done", tx_ready, 1);
        @(negedge clk);
        chk("hold_second_accept", acc_cnt - a0, 2);
        chk("hold_busy_again", tx_busy, 1);
        tx_valid = 1'b0;
        inhibit_phase();
        d0 = done_cnt;
        e0 = err_cnt;
        dev_clock(8'hAA, 1'b1, 7, 7, 0);
        wait_result(d0, e0, 1'b1);

        // Randomised frames, ACK/NACK and device clock phases
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom_range(0, 255));
            ra = 1'($urandom_range(0, 1));
            send_frame(rb, ra, $urandom_range(6, 10), $urandom_range(6, 10));
        end

        chk("done_err_never_together", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000: system clock frequency in Hz.
REQ-002 Parameter INHIBIT_US, default 120: host clock-inhibit hold time in microseconds.
REQ-003 Parameter TIMEOUT_US, default 20_000: maximum time from clock release to device acknowledge.
REQ-004 clk  input  1  system clock; reset is synchronous, active-high, input, 1 bit.
REQ-005 tx_valid  input  1  request to send tx_data.
REQ-006 tx_data  input  8  command byte to the device, for example 0xED (set LEDs) or 0xFF (reset).
REQ-007 tx_ready  output  1  high only in IDLE; a byte is accepted when tx_valid && tx_ready.
REQ-008 tx_busy  output  1  high from accept until the return to IDLE; the paired receiver gates key decoding with it.
REQ-009 tx_done  output  1  one-cycle pulse on successful completion.
REQ-010 tx_err  output  1  one-cycle pulse on timeout, or on missing ACK when the ACK check is compiled in.
REQ-011 ps2_clk  inout  1  open-drain: the block drives only 0 or high-Z.
REQ-012 ps2_data  inout  1  open-drain: the block drives only 0 or high-Z.

Function
REQ-013 The byte SHALL be latched on accept; tx_data changes after accept SHALL have no effect.
REQ-014 ps2_clk and ps2_data inputs SHALL be 2-FF synchronised; a falling edge is a synchronised 1->0 transition, detected one cycle later.
REQ-015 The state machine SHALL have states IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
REQ-016 IDLE -> INHIBIT on accept; INHIBIT SHALL drive ps2_clk low for exactly INHIBIT_CYCLES = CLK_HZ/1_000_000*INHIBIT_US cycles.
REQ-017 On inhibit expiry -> REQ: drive ps2_data low (start bit) for 1 cycle, then release ps2_clk; REQ -> SHIFT on the next cycle.
REQ-018 In SHIFT, falling edges 1-8 SHALL present data bits 0-7, LSB first.
REQ-019 Falling edge 9 SHALL present odd parity, equal to the inverse of the XOR of the 8 bits.
REQ-020 Falling edge 10 SHALL release ps2_data (stop bit); the state then moves to ACK.
REQ-021 In ACK, on falling edge 11 the synchronised ps2_data is sampled: low means ACK, high means NACK.
REQ-022 The state then moves to WAIT_IDLE, which waits until both synchronised lines are high.
REQ-023 On leaving WAIT_IDLE, tx_done or tx_err SHALL pulse in the same cycle the state returns to IDLE.
REQ-024 A 4-bit bit counter (0-11) SHALL count falling edges; its value is never used outside SHIFT/ACK.
REQ-025 The timeout counter starts at clock release and stops in WAIT_IDLE.
REQ-026 On timeout expiry (TIMEOUT_CYCLES = CLK_HZ/1_000_000*TIMEOUT_US), the block SHALL release both lines, pulse tx_err and enter IDLE.
REQ-027 tx_valid while busy SHALL be ignored; tx_done and tx_err SHALL never assert together.
REQ-028 Outside INHIBIT/REQ/SHIFT the block SHALL drive neither line.

Reset
REQ-029 Reset SHALL force IDLE, release both lines (high-Z) on the next edge, and clear both counters and the shift register.
REQ-030 After reset, tx_ready=1, tx_busy=0, tx_done=0, tx_err=0.
REQ-031 Reset mid-transfer SHALL abort without a tx_done or tx_err pulse, and reset wins over a simultaneous tx_valid.

Configuration
REQ-032 Macro PS2_TX_ACK_CHECK_EN: when defined, a NACK at edge 11 SHALL pulse tx_err instead of tx_done.
REQ-033 When PS2_TX_ACK_CHECK_EN is undefined, edge 11 is counted but not checked, and completion always pulses tx_done.

Structure
REQ-034 Shared package ps2_pkg SHALL hold the state enumeration and the default timing constants (INHIBIT_US, TIMEOUT_US).
REQ-035 The sub-module ps2_sync SHALL hold the 2-FF synchroniser and falling-edge detector, with one instance per line.

Verification
REQ-036 Send 0xED with the device model ACKing: ps2_clk low for INHIBIT_CYCLES, data bits 1,0,1,1,0,1,1,1, parity 1, stop released, then tx_done pulses once.
REQ-037 Send 0xF4: parity 0; send 0x00: parity 1; in both cases the data line must be released at edge 10.
REQ-038 Device model NACKs 0xFF: with PS2_TX_ACK_CHECK_EN, tx_err pulses; without it, tx_done pulses.
REQ-039 Device model never clocks: after TIMEOUT_CYCLES, tx_err pulses, both lines are high-Z and tx_ready=1.
REQ-040 Assert reset at edge 5 of 0xED: the lines release next cycle, no done/err pulse, and a following 0xFF transfer completes.
REQ-041 Hold tx_valid with 0xAA while busy: exactly one transfer occurs and a second accept happens only after IDLE.
